cic_decimator: RTL and testbench

CIC_DECIMATOR -- requirements
Module: cic_decimator

---
 rtl/cic_decimator.sv | 224 ++++++++++++++++++++++
 tb/tb_cic_decimator.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decimator.sv
// cic_decimator: N-stage CIC decimator for time-multiplexed 1-bit PDM channels.
//
// Each accepted PDM bit (+1/-1) updates its channel's integrator cascade and
// decimation counter. On every R-th sample of a channel the comb section runs
// on the following clock, and the result is loaded into a single-entry output
// register with a valid/ready handshake. A result that arrives while the
// output register is still waiting is dropped and raises the sticky o_overrun.
//
// Optional feature (compile-time macro):
//   CIC_DECIMATOR_ROUND_EN - round-half-up to OW bits instead of truncating.
module cic_decimator #(
  parameter  int N   = 4,
  parameter  int R   = 32,
  parameter  int CH  = 2,
  parameter  int OW  = 16,
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           i_reset_n,
  input  logic           i_valid,
  input  logic [CHW-1:0] i_ch,
  input  logic           i_data,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [CHW-1:0] o_ch,
  output logic [OW-1:0]  o_data,
  output logic           o_overrun
);

  // Internal width: enough headroom for a gain of R^N plus sign.
  localparam int W    = N * $clog2(R) + 2;
  localparam int CW   = $clog2(R);
  localparam int CHW1 = CHW + 1;

  localparam logic [CW-1:0]  CNT_LAST = CW'(R - 1);
  localparam logic [CHW:0]   CH_LIM   = CHW1'(CH);

`ifdef CIC_DECIMATOR_ROUND_EN
  // Half an output LSB; zero when no bits are discarded.
  localparam logic signed [W-1:0] RND_BIAS =
    (W > OW) ? (W'(1) << ((W > OW) ? (W - OW - 1) : 0)) : '0;
`endif

  // Parameter sanity checks at elaboration.
  if (OW > W) begin : g_ow_check
    $error("cic_decimator: OW=%0d exceeds internal width W=%0d", OW, W);
  end
  if (N < 1 || N > 6) begin : g_n_check
    $error("cic_decimator: N=%0d outside 1..6", N);
  end
  if (R < 2 || R > 256 || (1 << $clog2(R)) != R) begin : g_r_check
    $error("cic_decimator: R=%0d must be a power of two in 2..256", R);
  end
  if (CH < 1 || CH > 8) begin : g_ch_check
    $error("cic_decimator: CH=%0d outside 1..8", CH);
  end

  // Map a PDM bit to +1 / -1 at full internal width.
  function automatic logic signed [W-1:0] pdm_step(input logic bit_in);
    logic signed [W-1:0] step;
    step = '1;
    if (bit_in) step = W'(1);
    return step;
  endfunction

  // Reduce a W-bit comb result to the OW-bit output sample.
  function automatic logic [OW-1:0] scale_out(input logic signed [W-1:0] v);
    logic signed [W-1:0] t;
    t = v;
`ifdef CIC_DECIMATOR_ROUND_EN
    t = v + RND_BIAS;
`endif
    return t[W-1:W-OW];
  endfunction

  // Per-channel state.
  logic signed [W-1:0] integ_q [CH][N];
  logic signed [W-1:0] integ_d [CH][N];
  logic signed [W-1:0] dly_q   [CH][N];
  logic signed [W-1:0] dly_d   [CH][N];
  logic [CW-1:0]       cnt_q   [CH];
  logic [CW-1:0]       cnt_d   [CH];

  // Decimation event travelling from the integrator stage to the comb stage.
  logic                vld_p1_q;
  logic                vld_p1_d;
  logic [CHW-1:0]      ch_p1_q;
  logic [CHW-1:0]      ch_p1_d;

  // Comb output of the event channel.
  logic signed [W-1:0] comb_y;

  // Output register.
  logic                o_valid_q;
  logic                o_valid_d;
  logic [CHW-1:0]      o_ch_q;
  logic [CHW-1:0]      o_ch_d;
  logic [OW-1:0]       o_data_q;
  logic [OW-1:0]       o_data_d;
  logic                o_overrun_q;
  logic                o_overrun_d;

  logic                accept;

  // ---- stage p0: input acceptance, integrator cascade, decimation counter ----
  // Out-of-range channel numbers are ignored entirely.
  assign accept = i_valid && ({1'b0, i_ch} < CH_LIM);

  // Advance the addressed channel's integrators (registered cascade) and counter.
  always_comb begin
    integ_d  = integ_q;
    cnt_d    = cnt_q;
    vld_p1_d = 1'b0;
    ch_p1_d  = ch_p1_q;
    if (accept) begin
      integ_d[i_ch][0] = integ_q[i_ch][0] + pdm_step(i_data);
      for (int k = 1; k < N; k++) begin
        integ_d[i_ch][k] = integ_q[i_ch][k] + integ_q[i_ch][k-1];
      end
      if (cnt_q[i_ch] == CNT_LAST) begin
        cnt_d[i_ch] = '0;
        vld_p1_d    = 1'b1;
        ch_p1_d     = i_ch;
      end else begin
        cnt_d[i_ch] = cnt_q[i_ch] + CW'(1);
      end
    end
  end

  // Integrator and counter state, cleared asynchronously.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int c = 0; c < CH; c++) begin
        cnt_q[c] <= '0;
        for (int k = 0; k < N; k++) begin
          integ_q[c][k] <= '0;
        end
      end
    end else begin
      integ_q <= integ_d;
      cnt_q   <= cnt_d;
    end
  end

  // Event handoff register into the comb stage.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vld_p1_q <= 1'b0;
      ch_p1_q  <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      ch_p1_q  <= ch_p1_d;
    end
  end

  // ---- stage p1: comb section on the event channel ----
  // The last integrator already holds the R-th sample's contribution here;
  // a new sample on the same channel this cycle only lands at the next edge.
  always_comb begin
    logic signed [W-1:0] acc;
    dly_d = dly_q;
    acc   = integ_q[ch_p1_q][N-1];
    for (int k = 0; k < N; k++) begin
      if (vld_p1_q) dly_d[ch_p1_q][k] = acc;
      acc = acc - dly_q[ch_p1_q][k];
    end
    comb_y = acc;
  end

  // Comb delay state, cleared asynchronously.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < N; k++) begin
          dly_q[c][k] <= '0;
        end
      end
    end else begin
      dly_q <= dly_d;
    end
  end

  // ---- output register: load, hold under backpressure, drop on overrun ----
  // A load while the held sample is not being taken drops the new sample;
  // a load coinciding with a handshake replaces the sample seamlessly.
  always_comb begin
    o_valid_d   = o_valid_q;
    o_ch_d      = o_ch_q;
    o_data_d    = o_data_q;
    o_overrun_d = o_overrun_q;
    if (vld_p1_q) begin
      if (o_valid_q && !o_ready) begin
        o_overrun_d = 1'b1;
      end else begin
        o_valid_d = 1'b1;
        o_ch_d    = ch_p1_q;
        o_data_d  = scale_out(comb_y);
      end
    end else if (o_valid_q && o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  // Output register state; o_overrun is only ever cleared by reset.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid_q   <= 1'b0;
      o_ch_q      <= '0;
      o_data_q    <= '0;
      o_overrun_q <= 1'b0;
    end else begin
      o_valid_q   <= o_valid_d;
      o_ch_q      <= o_ch_d;
      o_data_q    <= o_data_d;
      o_overrun_q <= o_overrun_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_ch      = o_ch_q;
  assign o_data    = o_data_q;
  assign o_overrun = o_overrun_q;

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: self-checking bench for cic_decimator.
// The reference model treats the filter as a plain FIR: each decimated output
// is the input history convolved with an N-fold boxcar of length R (delayed by
// N-1 samples for the registered integrator cascade), scaled to OW bits.
`timescale 1ns/1ps
module tb_cic_decimator;

  localparam int N   = 4;
  localparam int R   = 32;
  localparam int CH  = 2;
  localparam int OW  = 16;
  localparam int CHW = 1;
  localparam int W   = N * $clog2(R) + 2;
  localparam int HL  = N * (R - 1) + 1;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [OW-1:0]  data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_valid;
  logic [CHW-1:0] i_ch;
  logic           i_data;
  logic           o_valid;
  logic           o_ready;
  logic [CHW-1:0] o_ch;
  logic [OW-1:0]  o_data;
  logic           o_overrun;

  logic           r_valid;
  logic [0:0]     r_ch;
  logic           r_data;
  logic           r_ready;
  logic           r_o_valid;
  logic [0:0]     r_o_ch;
  logic [1:0]     r_o_data;
  logic           r_o_overrun;

  int     checks   = 0;
  int     failures = 0;
  longint h [HL];
  int     hist [CH][$];
  exp_t   exp_q [$];
  logic [OW-1:0] last_out [CH];
  int     n_out [CH];

  always #5 clk = ~clk;

  cic_decimator #(.N(N), .R(R), .CH(CH), .OW(OW)) dut (
    .clk       (clk),
    .i_reset_n (rst_n),
    .i_valid   (i_valid),
    .i_ch      (i_ch),
    .i_data    (i_data),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_ch      (o_ch),
    .o_data    (o_data),
    .o_overrun (o_overrun)
  );

  cic_decimator #(.N(1), .R(64), .CH(2), .OW(2)) dut_rnd (
    .clk       (clk),
    .i_reset_n (rst_n),
    .i_valid   (r_valid),
    .i_ch      (r_ch),
    .i_data    (r_data),
    .o_valid   (r_o_valid),
    .o_ready   (r_ready),
    .o_ch      (r_o_ch),
    .o_data    (r_o_data),
    .o_overrun (r_o_overrun)
  );

  // Impulse response of N cascaded length-R boxcars.
  task automatic build_h();
    longint t [HL];
    for (int i = 0; i < HL; i++) h[i] = (i < R) ? 1 : 0;
    for (int s = 1; s < N; s++) begin
      for (int i = 0; i < HL; i++) begin
        t[i] = 0;
        for (int k = 0; k < R; k++) if (i - k >= 0) t[i] += h[i-k];
      end
      h = t;
    end
  endtask

  function automatic longint cic_ref(int c);
    longint acc;
    int     n;
    int     idx;
    acc = 0;
    n   = hist[c].size() - 1;
    for (int j = 0; j < HL; j++) begin
      idx = n - (N - 1) - j;
      if (idx >= 0) acc += h[j] * hist[c][idx];
    end
    return acc;
  endfunction

  function automatic logic [OW-1:0] to_out(longint y);
    longint v;
    v = y;
`ifdef CIC_DECIMATOR_ROUND_EN
    v = v + (longint'(1) <<< (W - OW - 1));
`endif
    v = v >>> (W - OW);
    return v[OW-1:0];
  endfunction

  task automatic model_push(int c, int b);
    exp_t e;
    hist[c].push_back((b != 0) ? 1 : -1);
    if (hist[c].size() % R == 0) begin
      e.ch   = CHW'(c);
      e.data = to_out(cic_ref(c));
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < CH; c++) begin
      hist[c].delete();
      last_out[c] = '0;
      n_out[c]    = 0;
    end
    exp_q.delete();
  endtask

  // Apply one input beat (call just after a falling edge).
  task automatic drive(input logic v, input int c, input int b);
    i_valid = v;
    i_ch    = CHW'(c);
    i_data  = (b != 0);
    if (v && c < CH) model_push(c, b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_valid = 1'b0; i_ch = '0; i_data = 1'b0; o_ready = 1'b1;
    r_valid = 1'b0; r_ch = '0; r_data = 1'b0; r_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  // Stream stimulus of a given kind and compare every handshaken output
  // against the model; mode 0 DC, 1 zero-mean, 2 random, 3 ch0-only random.
  task automatic stream(int mode, int ncyc, string tag);
    exp_t e;
    int   c;
    int   b;
    logic v;
    for (int t = 0; t < ncyc + 4; t++) begin
      @(negedge clk);
      if (o_valid && o_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s_out: got unexpected ch=%0d data=%h, required no output", tag, o_ch, o_data);
        end else begin
          e = exp_q.pop_front();
          if (o_ch !== e.ch || o_data !== e.data) begin
            failures++;
            $display("FAIL %s_out: got ch=%0d data=%h, required ch=%0d data=%h", tag, o_ch, o_data, e.ch, e.data);
          end
        end
        last_out[o_ch] = o_data;
        n_out[o_ch]++;
      end
      if (t < ncyc) begin
        v = 1'b1;
        case (mode)
          0: begin c = t % 2; b = (c == 0) ? 1 : 0; end
          1: begin c = t % 2; b = (c == 0) ? ((t / 2) % 2) : int'($urandom_range(1, 0)); end
          2: begin
               v = ($urandom_range(3, 0) != 0);
               c = int'($urandom_range(CH - 1, 0));
               b = int'($urandom_range(1, 0));
             end
          default: begin c = 0; b = int'($urandom_range(1, 0)); end
        endcase
        drive(v, c, b);
      end else begin
        drive(1'b0, 0, 0);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d outputs missing, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    i_valid = 1'b1; i_ch = '0; i_data = 1'b1; o_ready = 1'b1;
    r_valid = 1'b1; r_ch = '0; r_data = 1'b1; r_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_ch !== '0 || o_data !== '0 || o_overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b ch=%0d data=%h ovr=%b, required all 0", o_valid, o_ch, o_data, o_overrun);
    end
    checks++;
    if (r_o_valid !== 1'b0 || r_o_data !== 2'd0 || r_o_overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs_rnd: got v=%b data=%h ovr=%b, required all 0", r_o_valid, r_o_data, r_o_overrun);
    end
    i_valid = 1'b0; r_valid = 1'b0;
    rst_n = 1'b1;
    clear_model();
    repeat (4) @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got o_valid=%b, required 0", o_valid);
    end
  endtask

  task automatic test_dc();
    do_reset();
    stream(0, 2 * R * 6, "dc");
    checks++;
    if (n_out[0] < 5 || n_out[1] < 5) begin
      failures++;
      $display("FAIL dc_count: got ch0=%0d ch1=%0d outputs, required >=5 each", n_out[0], n_out[1]);
    end
    checks++;
    if (last_out[0] !== 16'h4000) begin
      failures++;
      $display("FAIL dc_ch0: got %h, required 4000", last_out[0]);
    end
    checks++;
    if (last_out[1] !== 16'hC000) begin
      failures++;
      $display("FAIL dc_ch1: got %h, required c000", last_out[1]);
    end
    checks++;
    if (o_overrun !== 1'b0) begin
      failures++;
      $display("FAIL dc_overrun: got %b, required 0", o_overrun);
    end
  endtask

  task automatic test_zero_mean();
    do_reset();
    stream(1, 2 * R * 6, "zero_mean");
    checks++;
    if (n_out[0] < 5 || last_out[0] !== 16'h0000) begin
      failures++;
      $display("FAIL zero_mean_ch0: got %h after %0d outputs, required 0000", last_out[0], n_out[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    stream(2, 1500, "random");
  endtask

  task automatic test_latency();
    int early_bad;
    early_bad = 0;
    do_reset();
    for (int t = 0; t < R; t++) begin
      @(negedge clk);
      if (o_valid !== 1'b0) early_bad++;
      drive(1'b1, 0, int'($urandom_range(1, 0)));
    end
    checks++;
    if (early_bad != 0) begin
      failures++;
      $display("FAIL latency_early: got %0d cycles with o_valid=1, required 0", early_bad);
    end
    @(negedge clk);
    drive(1'b0, 0, 0);
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_c1: got o_valid=%b, required 0", o_valid);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_ch !== '0 || o_data !== exp_q[0].data) begin
      failures++;
      $display("FAIL latency_c2: got v=%b ch=%0d data=%h, required v=1 ch=0 data=%h", o_valid, o_ch, o_data, exp_q[0].data);
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_reset();
    o_ready = 1'b0;
    for (int t = 0; t < 2 * R; t++) begin
      @(negedge clk);
      if (t == R + 4) begin
        checks++;
        if (o_valid !== 1'b1 || o_overrun !== 1'b0 || o_data !== exp_q[0].data) begin
          failures++;
          $display("FAIL bp_first: got v=%b ovr=%b data=%h, required v=1 ovr=0 data=%h", o_valid, o_overrun, o_data, exp_q[0].data);
        end
      end
      drive(1'b1, 0, int'($urandom_range(1, 0)));
    end
    @(negedge clk);
    drive(1'b0, 0, 0);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_ch !== '0 || o_data !== exp_q[0].data || o_overrun !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold: got v=%b ch=%0d data=%h ovr=%b, required v=1 ch=0 data=%h ovr=1", o_valid, o_ch, o_data, o_overrun, exp_q[0].data);
    end
    o_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_overrun !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got v=%b ovr=%b, required v=0 ovr=1", o_valid, o_overrun);
    end
    exp_q.delete();
    stream(3, R, "bp_after");
    checks++;
    if (o_overrun !== 1'b1) begin
      failures++;
      $display("FAIL bp_sticky: got ovr=%b, required 1", o_overrun);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    o_ready = 1'b0;
    for (int t = 0; t < R + 10; t++) begin
      @(negedge clk);
      drive(1'b1, 0, int'($urandom_range(1, 0)));
    end
    @(negedge clk);
    drive(1'b0, 0, 0);
    checks++;
    if (o_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: got o_valid=%b, required 1", o_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ch !== '0 || o_data !== '0 || o_overrun !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async: got v=%b ch=%0d data=%h ovr=%b, required all 0", o_valid, o_ch, o_data, o_overrun);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    o_ready = 1'b1;
    stream(3, R, "rst_mid_after");
    checks++;
    if (n_out[0] != 1) begin
      failures++;
      $display("FAIL rst_mid_count: got %0d outputs, required 1", n_out[0]);
    end
  endtask

  task automatic test_rounding();
    logic [1:0] want;
`ifdef CIC_DECIMATOR_ROUND_EN
    want = 2'd1;
`else
    want = 2'd0;
`endif
    do_reset();
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      r_valid = 1'b1;
      r_ch    = '0;
      r_data  = (t < 48);
    end
    @(negedge clk);
    r_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (r_o_valid !== 1'b1 || r_o_ch !== 1'b0 || r_o_data !== want) begin
      failures++;
      $display("FAIL rounding: got v=%b ch=%0d data=%0d, required v=1 ch=0 data=%0d", r_o_valid, r_o_ch, r_o_data, want);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_valid = 1'b0; i_ch = '0; i_data = 1'b0; o_ready = 1'b1;
    r_valid = 1'b0; r_ch = '0; r_data = 1'b0; r_ready = 1'b1;
    build_h();
    test_reset();
    test_dc();
    test_zero_mean();
    test_random();
    test_latency();
    test_backpressure();
    test_reset_midframe();
    test_rounding();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
